// File: rtl/axi4lite_mmio_master.sv
// axi4lite_mmio_master
// Single-outstanding AXI4-lite initiator. A valid/ready command port is turned
// into exactly one AXI4-lite read or write, and the outcome is returned on a
// valid/ready response port. A per-transaction timeout reports a silent slave
// while still honouring AXI handshake rules: pending valids stay up until
// their handshake, and a late B/R beat is absorbed before the next command.
module axi4lite_mmio_master #(
    parameter int              ALEN      = 32,
    parameter logic [ALEN-1:0] ADDR_MASK = {ALEN{1'b1}},
    parameter int              TIMEOUT   = 1024,
    parameter int              TIMEOUT_W = 16
) (
    input  logic            aclk,
    input  logic            aresetn,
    // write address channel
    output logic            awvalid,
    input  logic            awready,
    output logic [ALEN-1:0] awaddr,
    output logic [2:0]      awprot,
    // write data channel
    output logic            wvalid,
    input  logic            wready,
    output logic [63:0]     wdata,
    output logic [7:0]      wstrb,
    // write response channel
    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp,
    // read address channel
    output logic            arvalid,
    input  logic            arready,
    output logic [ALEN-1:0] araddr,
    output logic [2:0]      arprot,
    // read data channel
    input  logic            rvalid,
    output logic            rready,
    input  logic [63:0]     rdata,
    input  logic [1:0]      rresp,
    // command port
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [ALEN-1:0] req_addr,
    input  logic [63:0]     req_wdata,
    // response port
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [63:0]     rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic            rsp_err,
    output logic            rsp_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0]           RESP_OKAY = 2'b00;
    localparam bit                   TMO_EN    = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TIMEOUT_W'(TIMEOUT - 1);

    // registered state
    state_t               state_r;
    logic                 awvalid_r;
    logic                 wvalid_r;
    logic                 arvalid_r;
    logic                 bready_r;
    logic                 rready_r;
    logic                 drained_r;
    logic [TIMEOUT_W-1:0] cnt_r;
    logic [ALEN-1:0]      addr_r;
    logic [63:0]          wdata_r;
    logic                 rsp_valid_r;
    logic [63:0]          rsp_rdata_r;
    logic [1:0]           rsp_resp_r;
    logic                 rsp_err_r;
    logic                 rsp_timeout_r;

    // next-state values
    state_t               state_n;
    logic                 awvalid_n;
    logic                 wvalid_n;
    logic                 arvalid_n;
    logic                 bready_n;
    logic                 rready_n;
    logic                 drained_n;
    logic [TIMEOUT_W-1:0] cnt_n;
    logic [ALEN-1:0]      addr_n;
    logic [63:0]          wdata_n;
    logic                 rsp_valid_n;
    logic [63:0]          rsp_rdata_n;
    logic [1:0]           rsp_resp_n;
    logic                 rsp_err_n;
    logic                 rsp_timeout_n;

    // handshake and helper terms
    logic aw_hs_s;
    logic w_hs_s;
    logic ar_hs_s;
    logic b_hs_s;
    logic r_hs_s;
    logic accept_s;
    logic tmo_hit_s;
    logic beat_done_s;
    logic pend_s;

    // A response code other than OKAY is reported as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

    assign req_ready = (state_r == ST_IDLE) && aresetn;
    assign accept_s  = req_valid && req_ready;

    assign aw_hs_s = awvalid_r && awready;
    assign w_hs_s  = wvalid_r  && wready;
    assign ar_hs_s = arvalid_r && arready;
    assign b_hs_s  = bvalid    && bready_r;
    assign r_hs_s  = rvalid    && rready_r;

    // Expiry is judged on the count of the current cycle; a beat arriving in
    // the same cycle takes priority in the FSM below.
    assign tmo_hit_s = TMO_EN && (cnt_r == TMO_LAST);

    // Beat received now or earlier, and address/data valids still pending
    // after this cycle's handshakes.
    assign beat_done_s = drained_r || b_hs_s || r_hs_s;
    assign pend_s      = (awvalid_r && !aw_hs_s) || (wvalid_r && !w_hs_s) ||
                         (arvalid_r && !ar_hs_s);

    // Fixed and registered bus outputs.
    assign awvalid     = awvalid_r;
    assign awaddr      = addr_r;
    assign awprot      = 3'b000;
    assign wvalid      = wvalid_r;
    assign wdata       = wdata_r;
    assign wstrb       = 8'hFF;
    assign bready      = bready_r;
    assign arvalid     = arvalid_r;
    assign araddr      = addr_r;
    assign arprot      = 3'b000;
    assign rready      = rready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_resp    = rsp_resp_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_n       = state_r;
        // each valid/ready falls after its own handshake unless re-armed below
        awvalid_n     = awvalid_r && !aw_hs_s;
        wvalid_n      = wvalid_r  && !w_hs_s;
        arvalid_n     = arvalid_r && !ar_hs_s;
        bready_n      = bready_r  && !b_hs_s;
        rready_n      = rready_r  && !r_hs_s;
        drained_n     = beat_done_s;
        cnt_n         = cnt_r;
        addr_n        = addr_r;
        wdata_n       = wdata_r;
        rsp_valid_n   = rsp_valid_r;
        rsp_rdata_n   = rsp_rdata_r;
        rsp_resp_n    = rsp_resp_r;
        rsp_err_n     = rsp_err_r;
        rsp_timeout_n = rsp_timeout_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_n    = req_addr & ADDR_MASK;
                    wdata_n   = req_wdata;
                    cnt_n     = {TIMEOUT_W{1'b0}};
                    drained_n = 1'b0;
                    if (req_write) begin
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        bready_n  = 1'b1;
                        state_n   = ST_WRITE;
                    end else begin
                        arvalid_n = 1'b1;
                        rready_n  = 1'b1;
                        state_n   = ST_READ;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_WRITE: begin
                cnt_n = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                if (b_hs_s) begin
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = 64'd0;
                    rsp_resp_n    = bresp;
                    rsp_err_n     = resp_is_err(bresp);
                    rsp_timeout_n = 1'b0;
                    state_n       = ST_RESP;
                end else if (tmo_hit_s) begin
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = 64'd0;
                    rsp_resp_n    = 2'b00;
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                    state_n       = ST_RESP;
                end else begin
                    state_n = ST_WRITE;
                end
            end

            ST_READ: begin
                cnt_n = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                if (r_hs_s) begin
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = rdata;
                    rsp_resp_n    = rresp;
                    rsp_err_n     = resp_is_err(rresp);
                    rsp_timeout_n = 1'b0;
                    state_n       = ST_RESP;
                end else if (tmo_hit_s) begin
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = 64'd0;
                    rsp_resp_n    = 2'b00;
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                    state_n       = ST_RESP;
                end else begin
                    state_n = ST_READ;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    // a timed-out transaction may still owe a beat or a handshake
                    if (beat_done_s && !pend_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DRAIN;
                    end
                end else begin
                    state_n = ST_RESP;
                end
            end

            ST_DRAIN: begin
                if (beat_done_s && !pend_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DRAIN;
                end
            end

            default: begin
                state_n     = ST_IDLE;
                awvalid_n   = 1'b0;
                wvalid_n    = 1'b0;
                arvalid_n   = 1'b0;
                bready_n    = 1'b0;
                rready_n    = 1'b0;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

    // State, bus and response registers with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= ST_IDLE;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            bready_r      <= 1'b0;
            rready_r      <= 1'b0;
            drained_r     <= 1'b0;
            cnt_r         <= {TIMEOUT_W{1'b0}};
            addr_r        <= {ALEN{1'b0}};
            wdata_r       <= 64'd0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 64'd0;
            rsp_resp_r    <= 2'b00;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            awvalid_r     <= awvalid_n;
            wvalid_r      <= wvalid_n;
            arvalid_r     <= arvalid_n;
            bready_r      <= bready_n;
            rready_r      <= rready_n;
            drained_r     <= drained_n;
            cnt_r         <= cnt_n;
            addr_r        <= addr_n;
            wdata_r       <= wdata_n;
            rsp_valid_r   <= rsp_valid_n;
            rsp_rdata_r   <= rsp_rdata_n;
            rsp_resp_r    <= rsp_resp_n;
            rsp_err_r     <= rsp_err_n;
            rsp_timeout_r <= rsp_timeout_n;
        end
    end

endmodule

// File: tb/tb_axi4lite_mmio_master.sv
// Self-checking bench for axi4lite_mmio_master: a small two-register AXI4-lite
// slave model with programmable channel latencies, a table of transactions
// and hand-written sequences for skew, timeout, backpressure and reset.
module tb_axi4lite_mmio_master;

    localparam int ALEN = 32;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  resp;
        logic        err;
        logic        tmo;
    } vec_t;

    logic            clk = 1'b0;
    logic            aresetn;
    logic            awvalid, awready;
    logic [ALEN-1:0] awaddr;
    logic [2:0]      awprot;
    logic            wvalid, wready;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic            arvalid, arready;
    logic [ALEN-1:0] araddr;
    logic [2:0]      arprot;
    logic            rvalid, rready;
    logic [63:0]     rdata;
    logic [1:0]      rresp;
    logic            req_valid, req_ready, req_write;
    logic [ALEN-1:0] req_addr;
    logic [63:0]     req_wdata;
    logic            rsp_valid, rsp_ready;
    logic [63:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_err, rsp_timeout;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    vec_t exp_q[$];

    // slave model knobs and observation counters
    int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    int n_b = 0, n_r = 0;

    axi4lite_mmio_master #(
        .ALEN      (ALEN),
        .ADDR_MASK (32'h0000_0FFF),
        .TIMEOUT   (8),
        .TIMEOUT_W (16)
    ) dut (
        .aclk        (clk),
        .aresetn     (aresetn),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .awprot      (awprot),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .bvalid      (bvalid),
        .bready      (bready),
        .bresp       (bresp),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddr      (araddr),
        .arprot      (arprot),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .rresp       (rresp),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout)
    );

    always #5 clk = ~clk;

    // cycle counter used to measure latencies
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: registers at 0x0 and 0x8, SLVERR elsewhere. It acts on the
    // falling edge; a ready/valid it raised there completes on the next rising
    // edge because the DUT's valids/readies are registered.
    initial begin : slave
        logic [63:0] regs [0:1];
        logic [31:0] s_awaddr, s_araddr;
        logic [63:0] s_wdata;
        logic        have_aw, have_w, have_ar, b_rdy_seen, r_rdy_seen;
        int          aw_cnt, w_cnt, ar_cnt, r_cnt;
        regs[0] = 64'd0; regs[1] = 64'd0;
        s_awaddr = 32'd0; s_araddr = 32'd0; s_wdata = 64'd0;
        have_aw = 1'b0; have_w = 1'b0; have_ar = 1'b0;
        b_rdy_seen = 1'b0; r_rdy_seen = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 64'd0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                arready = 1'b0; rvalid = 1'b0;
                have_aw = 1'b0; have_w = 1'b0; have_ar = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (awready) begin awready = 1'b0; have_aw = 1'b1; end
                if (wready)  begin wready  = 1'b0; have_w  = 1'b1; end
                if (bvalid && b_rdy_seen) begin bvalid = 1'b0; n_b++; end
                if (arready) begin arready = 1'b0; have_ar = 1'b1; end
                if (rvalid && r_rdy_seen) begin rvalid = 1'b0; n_r++; end
                if (awvalid && !have_aw) begin
                    if (aw_cnt >= aw_lat) begin awready = 1'b1; s_awaddr = awaddr; aw_cnt = 0; end
                    else aw_cnt++;
                end
                if (wvalid && !have_w) begin
                    if (w_cnt >= w_lat) begin wready = 1'b1; s_wdata = wdata; w_cnt = 0; end
                    else w_cnt++;
                end
                if (have_aw && have_w && !bvalid) begin
                    if (s_awaddr == 32'h0 || s_awaddr == 32'h8) begin
                        regs[s_awaddr[3]] = s_wdata;
                        bresp = 2'b00;
                    end else begin
                        bresp = 2'b10;
                    end
                    bvalid = 1'b1; have_aw = 1'b0; have_w = 1'b0;
                end
                if (bvalid) b_rdy_seen = bready;
                if (arvalid && !have_ar) begin
                    if (ar_cnt >= ar_lat) begin arready = 1'b1; s_araddr = araddr; ar_cnt = 0; end
                    else ar_cnt++;
                end
                if (have_ar && !rvalid) begin
                    if (r_cnt >= r_lat) begin
                        if (s_araddr == 32'h0 || s_araddr == 32'h8) begin
                            rdata = regs[s_araddr[3]]; rresp = 2'b00;
                        end else begin
                            rdata = 64'd0; rresp = 2'b10;
                        end
                        rvalid = 1'b1; have_ar = 1'b0; r_cnt = 0;
                    end else begin
                        r_cnt++;
                    end
                end
                if (rvalid) r_rdy_seen = rready;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Offer a command, record its expected response, return on the negedge
    // of the first cycle after the accept edge.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("req_ready_wait", req_ready, 1);
        accept_cyc = cyc;
        exp_q.push_back(v);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for a response, compare against the scoreboard, optionally hold
    // rsp_ready low for `hold` cycles, then consume it.
    task automatic wait_rsp(input int hold, input int exp_lat);
        int   n;
        vec_t e;
        logic bad;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("rsp_seen", rsp_valid, 1);
        if (exp_q.size() == 0) begin
            check("sb_nonempty", 64'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            if (exp_lat >= 0) check("latency", 64'(cyc - accept_cyc), 64'(exp_lat));
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", rsp_resp, e.resp);
            check("rsp_err", rsp_err, e.err);
            check("rsp_timeout", rsp_timeout, e.tmo);
            bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp ||
                    rsp_err !== e.err || rsp_timeout !== e.tmo || req_ready !== 1'b0) bad = 1'b1;
            end
            if (hold > 0) check("bp_stable", bad, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl [9];
        vec_t v;
        logic bad;
        int   b0, r0;

        tbl[0] = '{1'b1, 32'h0000_0000, 64'h0000_1122_3344_5566, 64'd0, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0000, 64'd0, 64'h0000_1122_3344_5566, 2'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0100, 64'd0, 64'd0, 2'd2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0008, 64'hA5A5_0F0F_1234_5678, 64'd0, 2'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'h1000_0008, 64'd0, 64'hA5A5_0F0F_1234_5678, 2'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_0104, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 2'd2, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_0000, 64'd0, 64'h0000_1122_3344_5566, 2'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 32'h0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 1'b0};

        aresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("wstrb", wstrb, 8'hFF);
        check("awprot", awprot, 0);
        check("arprot", arprot, 0);
        aresetn = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", req_ready, 1);

        // table of zero-wait transactions: response 3 cycles after accept
        for (int i = 0; i < 9; i++) begin
            send(tbl[i]);
            wait_rsp(0, 3);
        end

        // skewed write channels: W held off while AW completes at once
        w_lat = 5;
        b0 = n_b;
        v = '{1'b1, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 64'd0, 2'd0, 1'b0, 1'b0};
        send(v);
        @(negedge clk);
        check("skew_aw_dropped", awvalid, 0);
        check("skew_w_held", wvalid, 1);
        repeat (4) @(negedge clk);
        check("skew_w_still_held", wvalid, 1);
        @(negedge clk);
        check("skew_w_dropped", wvalid, 0);
        wait_rsp(0, 8);
        repeat (3) @(negedge clk);
        check("skew_one_b", 64'(n_b - b0), 1);
        check("skew_no_extra_rsp", rsp_valid, 0);
        w_lat = 0;

        // R beat in the very cycle the counter expires: the beat wins
        r_lat = 6;
        v = '{1'b0, 32'h0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 1'b0};
        send(v);
        wait_rsp(0, 9);

        // R beat one cycle late: timeout, beat absorbed while response is held
        r_lat = 7;
        r0 = n_r;
        v = '{1'b0, 32'h0000_0000, 64'd0, 64'd0, 2'd0, 1'b1, 1'b1};
        send(v);
        wait_rsp(0, 9);
        check("late1_req_ready", req_ready, 1);
        check("late1_beat_taken", 64'(n_r - r0), 1);

        // timeout, R beat at cycle 20: no new command until it is drained
        r_lat = 18;
        r0 = n_r;
        v = '{1'b0, 32'h0000_0000, 64'd0, 64'd0, 2'd0, 1'b1, 1'b1};
        send(v);
        wait_rsp(0, 9);
        bad = 1'b0;
        while (cyc - accept_cyc <= 20) begin
            if (req_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("drain_hold", bad, 0);
        check("drain_release", req_ready, 1);
        check("drain_beat_taken", 64'(n_r - r0), 1);
        r_lat = 0;

        // response backpressure for 10 cycles
        v = '{1'b0, 32'h0000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 2'd0, 1'b0, 1'b0};
        send(v);
        wait_rsp(10, 3);

        // reset in the middle of a read whose AR is still pending
        ar_lat = 20;
        v = '{1'b0, 32'h0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 1'b0};
        send(v);
        @(negedge clk);
        check("mid_ar_pending", arvalid, 1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_rready", rready, 0);
        check("mid_rst_awvalid", awvalid, 0);
        check("mid_rst_wvalid", wvalid, 0);
        check("mid_rst_bready", bready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        ar_lat = 0;
        aresetn = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        send(v);
        wait_rsp(0, 3);

        check("sb_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
